alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle control stage directly upstream of the 8-bit ALU.
- Fetches 16-bit instruction words over a req/ack handshake and decodes them into the ALU's one-hot operation strobes and Tgt1/Tgt2 selects.
- Issues write enables for the register bank (DR/R1) and the flags register, and maintains the program counter, including jumps resolved by the ALU's IJ output.

Parameters:
- PC_W, 8, program-counter and imem_addr width; must be ≤ 8.
- EXEC_CYC, 1, cycles spent in EXEC before WB; legal range 1..15.

Ports:
- clk input 1 system clock, rising edge.
- rst input 1 asynchronous active-low reset.
- run input 1 level; leaves IDLE when high.
- imem_req output 1 fetch request.
- imem_addr output PC_W fetch address; equals pc.
- imem_ack input 1 fetch data valid.
- imem_data input 16 instruction word.
- Tgt1 output 4 ALU operand-A select, instr[10:7].
- Tgt2 output 4 ALU operand-B select, instr[6:3].
- IADD ISUB IADC ISBB IMUL IDIV IINC IDEC ISHL ISHR INOT INEG IAND IOR IJMP IJA IJB IJE output 1 each ALU op strobes, at most one high.
- EALU output 1 ALU bus drive enable.
- IJ input 1 ALU jump-taken.
- Dout input 8 ALU result bus; carries the jump target for jump ops.
- reg_we output 1 write Dout to register Tgt1.
- r1_we output 1 write Dout_R1 to R1 (MUL/DIV only).
- flags_we output 1 load Flags_out into the flags register.
- pc output PC_W program counter.
- halted output 1 high in HALT.
- illegal output 1 sticky; set on an undefined opcode.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; pc=0; instruction register=0; illegal=0.
  - All strobes, EALU, imem_req, reg_we, r1_we, flags_we and halted are 0.
  - Tgt1=Tgt2=0.
  - Asserting reset in any state, including mid-fetch or mid-EXEC, aborts immediately; no write enable may glitch high.
- Opcode field instr[15:11]:
  - 0 NOP, 1 ADD, 2 SUB, 3 ADC, 4 SBB, 5 MUL, 6 DIV, 7 INC, 8 DEC, 9 SHL, 10 SHR, 11 NOT, 12 NEG, 13 AND, 14 OR, 15 JMP, 16 JA, 17 JB, 18 JE, 31 HLT.
  - 19..30 are illegal: set illegal and execute as NOP.
  - instr[2:0] is ignored.
- FSM, all outputs registered:
  - IDLE: wait for run=1, then go to FETCH.
  - FETCH: imem_req=1 and imem_addr=pc. On a rising edge with imem_ack=1, latch imem_data into the instruction register and go to DECODE. An ack sampled outside FETCH is ignored. There is no timeout; req stays high indefinitely.
  - DECODE: one cycle. Tgt1/Tgt2 become valid here and stay stable until the next DECODE. HLT goes to HALT; all others go to EXEC.
  - EXEC: the decoded strobe and EALU are held high for EXEC_CYC cycles, counted by an internal counter, then go to WB. A NOP or illegal opcode drives no strobe and EALU=0.
  - WB: one cycle. The strobe and EALU are still held so ALU outputs remain valid.
    - reg_we=1 for opcodes 1–14.
    - r1_we=1 for opcodes 5 and 6.
    - flags_we=1 for opcodes 1–14.
    - Jump ops (15–18): no reg_we and no flags_we. If IJ=1, pc <= Dout[PC_W-1:0]; otherwise pc <= pc+1.
    - Non-jump ops: pc <= pc+1; IJ is ignored.
    - Then go to FETCH, or IDLE if run=0.
  - HALT: halted=1, all strobes 0. The state is left only by reset.
- Arithmetic and boundary rules:
  - pc+1 wraps modulo 2^PC_W; PC_W-1 rolls over to 0 with no flag.
  - A jump to the current pc is legal and loops.
  - Dropping run mid-instruction still completes that instruction through WB.
  - Throughput: a NOP costs 3+EXEC_CYC cycles plus the fetch latency.
- Write enables are single-cycle pulses and never overlap a state change out of WB.

Test Plan:
- Reset and halt: reset, then run=1. Feed pc 0 = ADD (0x0888: Tgt1=1, Tgt2=1) with ack after 2 cycles, then pc 1 = HLT 0xF800. Required:
  - imem_addr 0 then 1.
  - IADD high during EXEC and WB.
  - reg_we and flags_we single pulses in WB with Tgt1=1.
  - halted=1 after the second DECODE; imem_req stays 0 afterwards.
- MUL with EXEC_CYC=3: feed 0x2888. Required: IMUL high 4 cycles, and r1_we and reg_we both pulse in the same WB cycle.
- Conditional jumps:
  - JE with IJ=1 and Dout=0x40: next imem_addr=0x40, no reg_we and no flags_we.
  - Same with IJ=0: next imem_addr=pc+1.
- Illegal opcode: feed 0xA000 (opcode 20). Required: illegal=1 and stays set, no strobes, no write enables, pc advances by 1.
- PC wrap: PC_W=8, execute a NOP at pc=0xFF. Required: next fetch address is 0x00.
- Reset mid-operation: assert rst low while in FETCH with ack pending, and again mid-EXEC. Required: outputs return to reset values asynchronously, and no reg_we, r1_we or flags_we pulse occurs.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetch/decode/execute/writeback control stage ahead of
// the 8-bit ALU. Fetches 16-bit words over req/ack, drives one-hot op
// strobes and operand selects, pulses bank/flags write enables in WB and
// steps or redirects the program counter.
module alu_op_sequencer #(
  parameter int PC_W     = 8,
  parameter int EXEC_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      Tgt1,
  output logic [3:0]      Tgt2,
  output logic            IADD,
  output logic            ISUB,
  output logic            IADC,
  output logic            ISBB,
  output logic            IMUL,
  output logic            IDIV,
  output logic            IINC,
  output logic            IDEC,
  output logic            ISHL,
  output logic            ISHR,
  output logic            INOT,
  output logic            INEG,
  output logic            IAND,
  output logic            IOR,
  output logic            IJMP,
  output logic            IJA,
  output logic            IJB,
  output logic            IJE,
  output logic            EALU,
  input  logic            IJ,
  input  logic [7:0]      Dout,
  output logic            reg_we,
  output logic            r1_we,
  output logic            flags_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  localparam logic [4:0] OP_FIRST = 5'd1;   // ADD
  localparam logic [4:0] OP_OR    = 5'd14;  // last register-writing op
  localparam logic [4:0] OP_JMP   = 5'd15;
  localparam logic [4:0] OP_JE    = 5'd18;  // last op with a strobe
  localparam logic [4:0] OP_MUL   = 5'd5;
  localparam logic [4:0] OP_DIV   = 5'd6;
  localparam logic [4:0] OP_ILO   = 5'd19;
  localparam logic [4:0] OP_IHI   = 5'd30;
  localparam logic [4:0] OP_HLT   = 5'd31;
  localparam logic [3:0] CNT_LAST = 4'(EXEC_CYC - 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [3:0]        tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic [17:0]       strb_q, strb_d;
  logic              ealu_q, ealu_d;
  logic              req_q, req_d;
  logic              reg_we_q, reg_we_d;
  logic              r1_we_q, r1_we_d;
  logic              flags_we_q, flags_we_d;
  logic              halted_q, halted_d;
  logic [4:0]        op_q, op_n;
  logic              is_jump_q;
  logic              unused_bits;

  assign op_q      = ir_q[15:11];
  assign op_n      = ir_d[15:11];
  assign is_jump_q = (op_q >= OP_JMP) && (op_q <= OP_JE);
  // operand selects come from their own registers; low word bits are don't-care
  assign unused_bits = ^{ir_q[10:0], Dout};

  // Sequencing: state, counter, pc, instruction register and operand selects
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    tgt1_d    = tgt1_q;
    tgt2_d    = tgt2_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          tgt1_d  = imem_data[10:7];
          tgt2_d  = imem_data[6:3];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        if (op_q == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
          if (op_q >= OP_ILO && op_q <= OP_IHI) illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_LAST) state_d = S_WB;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      S_WB: begin
        // ALU resolves the branch; IJ only matters for jump ops
        if (is_jump_q && IJ) pc_d = Dout[PC_W-1:0];
        else                 pc_d = pc_q + PC_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop
  always_comb begin
    strb_d     = '0;
    ealu_d     = 1'b0;
    reg_we_d   = 1'b0;
    r1_we_d    = 1'b0;
    flags_we_d = 1'b0;
    req_d      = (state_d == S_FETCH);
    halted_d   = (state_d == S_HALT);
    if ((state_d == S_EXEC || state_d == S_WB) && op_n >= OP_FIRST && op_n <= OP_JE) begin
      strb_d = 18'd1 << (op_n - OP_FIRST);
      ealu_d = 1'b1;
    end
    if (state_d == S_WB) begin
      reg_we_d   = (op_n >= OP_FIRST) && (op_n <= OP_OR);
      flags_we_d = (op_n >= OP_FIRST) && (op_n <= OP_OR);
      r1_we_d    = (op_n == OP_MUL) || (op_n == OP_DIV);
    end
  end

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      tgt1_q     <= '0;
      tgt2_q     <= '0;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
      strb_q     <= '0;
      ealu_q     <= 1'b0;
      req_q      <= 1'b0;
      reg_we_q   <= 1'b0;
      r1_we_q    <= 1'b0;
      flags_we_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      tgt1_q     <= tgt1_d;
      tgt2_q     <= tgt2_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      strb_q     <= strb_d;
      ealu_q     <= ealu_d;
      req_q      <= req_d;
      reg_we_q   <= reg_we_d;
      r1_we_q    <= r1_we_d;
      flags_we_q <= flags_we_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign Tgt1      = tgt1_q;
  assign Tgt2      = tgt2_q;
  assign EALU      = ealu_q;
  assign reg_we    = reg_we_q;
  assign r1_we     = r1_we_q;
  assign flags_we  = flags_we_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

  assign IADD = strb_q[0];
  assign ISUB = strb_q[1];
  assign IADC = strb_q[2];
  assign ISBB = strb_q[3];
  assign IMUL = strb_q[4];
  assign IDIV = strb_q[5];
  assign IINC = strb_q[6];
  assign IDEC = strb_q[7];
  assign ISHL = strb_q[8];
  assign ISHR = strb_q[9];
  assign INOT = strb_q[10];
  assign INEG = strb_q[11];
  assign IAND = strb_q[12];
  assign IOR  = strb_q[13];
  assign IJMP = strb_q[14];
  assign IJA  = strb_q[15];
  assign IJB  = strb_q[16];
  assign IJE  = strb_q[17];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, hand-written reset
// sequences, and random instruction streams against a per-instruction model.
module tb_alu_op_sequencer;
  localparam int EXC  = 3;
  localparam int WMAX = EXC + 6;

  logic clk, rst, run, imem_req, imem_ack, IJ, EALU;
  logic reg_we, r1_we, flags_we, halted, illegal;
  logic [7:0]  imem_addr, pc, Dout;
  logic [15:0] imem_data;
  logic [3:0]  Tgt1, Tgt2;
  logic IADD, ISUB, IADC, ISBB, IMUL, IDIV, IINC, IDEC, ISHL, ISHR;
  logic INOT, INEG, IAND, IOR, IJMP, IJA, IJB, IJE;
  logic [17:0] strb;

  assign strb = {IJE, IJB, IJA, IJMP, IOR, IAND, INEG, INOT, ISHR, ISHL,
                 IDEC, IINC, IDIV, IMUL, ISBB, IADC, ISUB, IADD};

  int errors = 0;
  int checks = 0;
  int we_glitch = 0;
  bit we_watch = 0;
  logic [7:0] m_pc;
  bit m_ill;

  typedef struct {
    logic [15:0] w; int lat; bit ij; logic [7:0] dv; bit drop;
    logic [7:0] addr; int idx; bit we; bit r1; bit fw;
    logic [7:0] nxt; logic [3:0] t1; logic [3:0] t2; bit ill;
  } vec_t;
  vec_t tbl[13];

  alu_op_sequencer #(.PC_W(8), .EXEC_CYC(EXC)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .Tgt1(Tgt1), .Tgt2(Tgt2),
    .IADD(IADD), .ISUB(ISUB), .IADC(IADC), .ISBB(ISBB), .IMUL(IMUL), .IDIV(IDIV),
    .IINC(IINC), .IDEC(IDEC), .ISHL(ISHL), .ISHR(ISHR), .INOT(INOT), .INEG(INEG),
    .IAND(IAND), .IOR(IOR), .IJMP(IJMP), .IJA(IJA), .IJB(IJB), .IJE(IJE),
    .EALU(EALU), .IJ(IJ), .Dout(Dout),
    .reg_we(reg_we), .r1_we(r1_we), .flags_we(flags_we),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // any rising write enable while watching is a failure
  always @(posedge reg_we or posedge r1_we or posedge flags_we)
    if (we_watch) we_glitch <= we_glitch + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {15'd0, imem_req, imem_addr, Tgt1, Tgt2, strb, EALU, reg_we, r1_we,
            flags_we, pc, halted, illegal};
  endfunction

  // Reference: what one instruction must do, from the opcode table
  function automatic void model(input logic [15:0] w, input bit ij, input logic [7:0] dv,
                                input logic [7:0] cur, output int idx, output bit we,
                                output bit r1, output bit fw, output bit ill,
                                output logic [7:0] nxt);
    int op;
    op  = int'(w[15:11]);
    idx = (op >= 1 && op <= 18) ? op - 1 : -1;
    we  = (op >= 1 && op <= 14);
    fw  = we;
    r1  = (op == 5 || op == 6);
    ill = (op >= 19 && op <= 30);
    nxt = (op >= 15 && op <= 18 && ij) ? dv : cur + 8'd1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0; IJ = 1'b0; Dout = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    m_pc = 8'd0;
    m_ill = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk(nm, imem_req, 1);
  endtask

  // Fetch and run one instruction, measuring its whole execution window
  task automatic do_instr(input logic [15:0] w, input int lat, input bit ij,
                          input logic [7:0] dv, input bit drop, input logic [7:0] addr,
                          input int idx, input bit e_we, input bit e_r1, input bit e_fw,
                          input logic [7:0] nxt, input logic [3:0] t1, input logic [3:0] t2,
                          input bit e_ill, input bit e_hlt);
    int n, good, other, ea, rw, r1c, fw, both, tchg, explen, ecyc;
    logic [17:0] ev;
    ev = (idx >= 0) ? (18'd1 << idx) : 18'd0;
    wait_req("fetch_req");
    chk("fetch_addr", imem_addr, addr);
    repeat (lat) @(negedge clk);
    chk("req_held", imem_req, 1);
    imem_ack = 1'b1; imem_data = w; IJ = ij; Dout = dv;
    @(negedge clk);
    imem_ack = 1'b0; imem_data = 16'($urandom);
    chk("tgt1", Tgt1, t1);
    chk("tgt2", Tgt2, t2);
    if (drop) run = 1'b0;
    good = 0; other = 0; ea = 0; rw = 0; r1c = 0; fw = 0; both = 0; tchg = 0;
    n = 0;
    while (imem_req !== 1'b1 && halted !== 1'b1 && n < WMAX) begin
      if (idx >= 0 && strb === ev) good++;
      if (strb !== 18'd0 && strb !== ev) other++;
      if (EALU) ea++;
      if (reg_we) rw++;
      if (r1_we) r1c++;
      if (flags_we) fw++;
      if (reg_we && r1_we) both++;
      if (Tgt1 !== t1 || Tgt2 !== t2) tchg++;
      imem_ack = 1'($urandom);  // stray acks outside FETCH
      @(negedge clk);
      n++;
    end
    imem_ack = 1'b0;
    explen = e_hlt ? 1 : (drop ? WMAX : EXC + 2);
    ecyc   = (idx >= 0) ? EXC + 1 : 0;
    chk("window_len", n, explen);
    chk("strobe_cycles", good, ecyc);
    chk("stray_strobe", other, 0);
    chk("ealu_cycles", ea, ecyc);
    chk("reg_we_pulses", rw, e_we);
    chk("r1_we_pulses", r1c, e_r1);
    chk("flags_we_pulses", fw, e_fw);
    chk("r1_with_reg_we", both, e_r1);
    chk("tgt_stable", tchg, 0);
    chk("illegal", illegal, e_ill);
    chk("halted", halted, e_hlt);
    if (!e_hlt) chk("pc_next", pc, nxt);
    run = 1'b1;
  endtask

  initial begin
    int g0, bad, idx;
    bit we, r1, fw, ill, ij, drop;
    logic [7:0] nxt, dv;
    logic [15:0] w;
    logic [4:0] op;

    tbl[0]  = '{16'h2888, 0, 1'b1, 8'h33, 1'b0, 8'h00,  4, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 4'd1,  1'b0};
    tbl[1]  = '{16'h9088, 1, 1'b1, 8'h40, 1'b0, 8'h01, 17, 1'b0, 1'b0, 1'b0, 8'h40, 4'd1, 4'd1,  1'b0};
    tbl[2]  = '{16'h9088, 0, 1'b0, 8'h77, 1'b0, 8'h40, 17, 1'b0, 1'b0, 1'b0, 8'h41, 4'd1, 4'd1,  1'b0};
    tbl[3]  = '{16'hA000, 2, 1'b1, 8'h10, 1'b0, 8'h41, -1, 1'b0, 1'b0, 1'b0, 8'h42, 4'd0, 4'd0,  1'b1};
    tbl[4]  = '{16'h0000, 0, 1'b0, 8'h00, 1'b0, 8'h42, -1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd0, 4'd0,  1'b1};
    tbl[5]  = '{16'h7800, 3, 1'b1, 8'hFF, 1'b0, 8'h43, 14, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd0, 4'd0,  1'b1};
    tbl[6]  = '{16'h0007, 0, 1'b1, 8'h55, 1'b0, 8'hFF, -1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0,  1'b1};
    tbl[7]  = '{16'h4B50, 1, 1'b1, 8'h99, 1'b0, 8'h00,  8, 1'b1, 1'b0, 1'b1, 8'h01, 4'd6, 4'd10, 1'b1};
    tbl[8]  = '{16'h3000, 0, 1'b0, 8'h00, 1'b0, 8'h01,  5, 1'b1, 1'b1, 1'b1, 8'h02, 4'd0, 4'd0,  1'b1};
    tbl[9]  = '{16'h8000, 0, 1'b1, 8'h02, 1'b0, 8'h02, 15, 1'b0, 1'b0, 1'b0, 8'h02, 4'd0, 4'd0,  1'b1};
    tbl[10] = '{16'h8800, 0, 1'b0, 8'h02, 1'b0, 8'h02, 16, 1'b0, 1'b0, 1'b0, 8'h03, 4'd0, 4'd0,  1'b1};
    tbl[11] = '{16'h3800, 0, 1'b1, 8'h80, 1'b1, 8'h03,  6, 1'b1, 1'b0, 1'b1, 8'h04, 4'd0, 4'd0,  1'b1};
    tbl[12] = '{16'h5800, 0, 1'b0, 8'h00, 1'b0, 8'h04, 10, 1'b1, 1'b0, 1'b1, 8'h05, 4'd0, 4'd0,  1'b1};

    rst = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 16'd0; IJ = 1'b0; Dout = 8'd0;

    // ADD at 0, HLT at 1, then nothing more may be fetched
    do_reset();
    run = 1'b1;
    do_instr(16'h0888, 2, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h01,
             4'd1, 4'd1, 1'b0, 1'b0);
    do_instr(16'hF800, 0, 1'b0, 8'h00, 1'b0, 8'h01, -1, 1'b0, 1'b0, 1'b0, 8'h01,
             4'd0, 4'd0, 1'b0, 1'b1);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b1 || strb !== 18'd0) bad++;
    end
    chk("halt_stays", bad, 0);

    // directed vector table
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 13; i++)
      do_instr(tbl[i].w, tbl[i].lat, tbl[i].ij, tbl[i].dv, tbl[i].drop, tbl[i].addr,
               tbl[i].idx, tbl[i].we, tbl[i].r1, tbl[i].fw, tbl[i].nxt,
               tbl[i].t1, tbl[i].t2, tbl[i].ill, 1'b0);

    // reset while FETCH has an ack pending
    do_reset();
    run = 1'b1;
    wait_req("rst_fetch_req");
    g0 = we_glitch;
    we_watch = 1'b1;
    imem_ack = 1'b1; imem_data = 16'h0888;
    #2 rst = 1'b0;
    #1 chk("rst_fetch_async", outs(), 64'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("rst_fetch_held", outs(), 64'd0);
    rst = 1'b1;
    wait_req("rst_fetch_refetch");
    chk("rst_fetch_addr", imem_addr, 8'h00);

    // reset in the middle of a MUL's EXEC phase
    imem_ack = 1'b1; imem_data = 16'h2888;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("rst_exec_pre", IMUL, 1);
    #2 rst = 1'b0;
    #1 chk("rst_exec_async", outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (EXC + 4) @(negedge clk);
    chk("rst_no_we", we_glitch - g0, 0);
    we_watch = 1'b0;

    // random instruction stream against the model
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op   = 5'($urandom_range(0, 30));
      w    = {op, 11'($urandom)};
      ij   = 1'($urandom);
      dv   = 8'($urandom);
      drop = ($urandom_range(0, 9) == 0);
      model(w, ij, dv, m_pc, idx, we, r1, fw, ill, nxt);
      m_ill = m_ill | ill;
      do_instr(w, $urandom_range(0, 3), ij, dv, drop, m_pc, idx, we, r1, fw, nxt,
               w[10:7], w[6:3], m_ill, 1'b0);
      m_pc = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
